// File: rtl/intersection_scheduler_if.sv
// Request/lamp bundle between the intersection scheduler and its surroundings.
// master: the side that raises pass requests and watches the lamps.
// slave:  the scheduler itself.
interface intersection_scheduler_if #(
    parameter int CNT_W = 5
);
    logic             req_a;
    logic             req_b;
    logic             a_r;
    logic             a_y;
    logic             a_g;
    logic             b_r;
    logic             b_y;
    logic             b_g;
    logic [2:0]       phase;
    logic [CNT_W-1:0] timer;
    logic             pend_a;
    logic             pend_b;

    modport master (
        output req_a, req_b,
        input  a_r, a_y, a_g, b_r, b_y, b_g, phase, timer, pend_a, pend_b
    );

    modport slave (
        input  req_a, req_b,
        output a_r, a_y, a_g, b_r, b_y, b_g, phase, timer, pend_a, pend_b
    );
endinterface

// File: rtl/intersection_scheduler.sv
// Two-head intersection sequencer: AR_A -> A_G -> A_Y -> AR_B -> B_G -> B_Y.
// Only one head is ever non-red; a latched request for the red side cuts the
// opposing green short once MIN_GREEN cycles of it have elapsed.
module intersection_scheduler #(
    parameter int CNT_W     = 5,
    parameter int ALLRED_T  = 2,
    parameter int GREEN_T   = 12,
    parameter int MIN_GREEN = 4,
    parameter int YELLOW_T  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    intersection_scheduler_if.slave bus
);

    typedef enum logic [2:0] {
        AR_A = 3'd0,
        A_G  = 3'd1,
        A_Y  = 3'd2,
        AR_B = 3'd3,
        B_G  = 3'd4,
        B_Y  = 3'd5
    } phase_t;

    localparam logic [CNT_W-1:0] T_AR  = CNT_W'(ALLRED_T);
    localparam logic [CNT_W-1:0] T_G   = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0] T_Y   = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] T_MIN = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    // Plain vector so the unused codes 6/7 are representable and recoverable.
    logic [2:0]       state;
    phase_t           nxt;
    phase_t           succ;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic [CNT_W-1:0] dur;
    logic             early;
    logic             illegal;
    logic             pend_a;
    logic             pend_b;
    logic             pend_a_nxt;
    logic             pend_b_nxt;
    logic             a_r, a_y, a_g, b_r, b_y, b_g;

    // State, phase timer and latched requests; reset forces all-red at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= AR_A;
            timer  <= ONE;
            pend_a <= 1'b0;
            pend_b <= 1'b0;
        end else begin
            state  <= nxt;
            timer  <= timer_nxt;
            pend_a <= pend_a_nxt;
            pend_b <= pend_b_nxt;
        end
    end

    // Next state: leave on expiry, or on an opposing request past min green.
    always_comb begin
        dur       = T_AR;
        succ      = AR_A;
        early     = 1'b0;
        illegal   = 1'b0;
        nxt       = AR_A;
        timer_nxt = ONE;
        case (state)
            AR_A: begin dur = T_AR; succ = A_G; end
            A_G: begin
                dur   = T_G;
                succ  = A_Y;
                early = pend_b && (timer >= T_MIN);
            end
            A_Y:  begin dur = T_Y;  succ = AR_B; end
            AR_B: begin dur = T_AR; succ = B_G;  end
            B_G: begin
                dur   = T_G;
                succ  = B_Y;
                early = pend_a && (timer >= T_MIN);
            end
            B_Y:  begin dur = T_Y;  succ = AR_A; end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            nxt       = AR_A;
            timer_nxt = ONE;
        end else if ((timer >= dur) || early) begin
            nxt       = succ;
            timer_nxt = ONE;
        end else begin
            nxt       = phase_t'(state);
            timer_nxt = timer + ONE;
        end
    end

    // Request latches: ignore a request for the side already green; the
    // edge that enters a side's green clears its latch, beating a new set.
    always_comb begin
        pend_a_nxt = pend_a | (bus.req_a && (state != A_G));
        pend_b_nxt = pend_b | (bus.req_b && (state != B_G));
        if ((nxt == A_G) && (state != A_G)) pend_a_nxt = 1'b0;
        if ((nxt == B_G) && (state != B_G)) pend_b_nxt = 1'b0;
    end

    // Lamp decode straight off the state register; anything unknown is all red.
    always_comb begin
        a_r = 1'b1; a_y = 1'b0; a_g = 1'b0;
        b_r = 1'b1; b_y = 1'b0; b_g = 1'b0;
        case (state)
            A_G: begin a_r = 1'b0; a_g = 1'b1; end
            A_Y: begin a_r = 1'b0; a_y = 1'b1; end
            B_G: begin b_r = 1'b0; b_g = 1'b1; end
            B_Y: begin b_r = 1'b0; b_y = 1'b1; end
            default: ;
        endcase
    end

    assign bus.a_r    = a_r;
    assign bus.a_y    = a_y;
    assign bus.a_g    = a_g;
    assign bus.b_r    = b_r;
    assign bus.b_y    = b_y;
    assign bus.b_g    = b_g;
    assign bus.phase  = state;
    assign bus.timer  = timer;
    assign bus.pend_a = pend_a;
    assign bus.pend_b = pend_b;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: directed scenarios plus random requests
// and random async resets, all compared every cycle to a reference model.
module tb_intersection_scheduler;

    localparam int CNT_W     = 5;
    localparam int ALLRED_T  = 2;
    localparam int GREEN_T   = 12;
    localparam int MIN_GREEN = 4;
    localparam int YELLOW_T  = 5;

    logic clk;
    logic rst_n;

    intersection_scheduler_if #(.CNT_W(CNT_W)) bus ();

    intersection_scheduler #(
        .CNT_W(CNT_W), .ALLRED_T(ALLRED_T), .GREEN_T(GREEN_T),
        .MIN_GREEN(MIN_GREEN), .YELLOW_T(YELLOW_T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase index 0..5 in ring order, cycle index within it.
    int DUR[6] = '{ALLRED_T, GREEN_T, YELLOW_T, ALLRED_T, GREEN_T, YELLOW_T};
    int m_ph, m_t;
    bit m_pa, m_pb;

    task automatic m_reset();
        m_ph = 0; m_t = 1; m_pa = 0; m_pb = 0;
    endtask

    // Advance the model by one clock given the requests seen in that cycle.
    task automatic mstep(input bit ra, input bit rb);
        int nph, nt;
        bit npa, npb, early;
        if (m_ph > 5) begin
            nph = 0; nt = 1;
        end else begin
            early = (m_ph == 1 && m_pb && m_t >= MIN_GREEN) ||
                    (m_ph == 4 && m_pa && m_t >= MIN_GREEN);
            if (m_t >= DUR[m_ph] || early) begin
                nph = (m_ph + 1) % 6; nt = 1;
            end else begin
                nph = m_ph; nt = m_t + 1;
            end
        end
        npa = m_pa || (ra && m_ph != 1);
        npb = m_pb || (rb && m_ph != 4);
        if (nph == 1 && m_ph != 1) npa = 0;
        if (nph == 4 && m_ph != 4) npb = 0;
        m_ph = nph; m_t = nt; m_pa = npa; m_pb = npb;
    endtask

    function automatic logic [5:0] lamps_of(input int ph);
        logic [5:0] l;
        l[5] = !(ph == 1 || ph == 2);
        l[4] = (ph == 2);
        l[3] = (ph == 1);
        l[2] = !(ph == 4 || ph == 5);
        l[1] = (ph == 5);
        l[0] = (ph == 4);
        return l;
    endfunction

    task automatic cmp_all();
        chk("phase", 32'(bus.phase), 32'(m_ph));
        chk("timer", 32'(bus.timer), 32'(m_t));
        chk("lamps", 32'({bus.a_r, bus.a_y, bus.a_g, bus.b_r, bus.b_y, bus.b_g}),
            32'(lamps_of(m_ph)));
        chk("pend", 32'({bus.pend_a, bus.pend_b}), 32'({m_pa, m_pb}));
        chk("excl", 32'(bus.a_r | bus.b_r), 32'd1);
        chk("onehot_a", 32'($countones({bus.a_r, bus.a_y, bus.a_g})), 32'd1);
        chk("onehot_b", 32'($countones({bus.b_r, bus.b_y, bus.b_g})), 32'd1);
    endtask

    // One cycle: compare at the negedge, then drive requests for the coming edge.
    task automatic cyc(input bit ra, input bit rb);
        @(negedge clk);
        cmp_all();
        bus.req_a = ra;
        bus.req_b = rb;
        mstep(ra, rb);
    endtask

    // Number of cycles the DUT stays in phase p, starting with the one on show.
    task automatic count_while(input int p, output int n);
        n = 0;
        while (32'(bus.phase) == p && n < 64) begin
            cyc(0, 0);
            n++;
        end
    endtask

    task automatic wait_m(input int ph, input int t);
        int n = 0;
        while (!(m_ph == ph && m_t == t) && n < 200) begin
            cyc(0, 0);
            n++;
        end
        chk("wait_model", 32'(n < 200), 32'd1);
    endtask

    task automatic wait_bus(input int p);
        int n = 0;
        while (32'(bus.phase) != p && n < 100) begin
            cyc(0, 0);
            n++;
        end
        chk("wait_phase", 32'(bus.phase), 32'(p));
    endtask

    // Async reset asserted mid-cycle; outputs must react without a clock edge.
    task automatic do_reset(input int hold);
        #2;
        rst_n = 1'b0;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        #1;
        chk("rst_phase", 32'(bus.phase), 32'd0);
        chk("rst_timer", 32'(bus.timer), 32'd1);
        chk("rst_pend", 32'({bus.pend_a, bus.pend_b}), 32'd0);
        chk("rst_lamps", 32'({bus.a_r, bus.a_y, bus.a_g, bus.b_r, bus.b_y, bus.b_g}),
            32'b100100);
        m_reset();
        repeat (hold) begin
            @(negedge clk);
            cmp_all();
        end
        rst_n = 1'b1;
        mstep(0, 0);
    endtask

    int n;
    int total;
    int exp_len[6];

    initial begin
        rst_n     = 1'b0;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        m_reset();
        repeat (3) begin
            @(negedge clk);
            cmp_all();
        end
        rst_n = 1'b1;
        mstep(0, 0);

        // First state after release is AR_A for ALLRED_T cycles.
        count_while(0, n);
        chk("init_arA_len", 32'(n), 32'd2);

        // Free run from A_G: every phase at full length, 38-cycle period.
        exp_len = '{12, 5, 2, 12, 5, 2};
        total = 0;
        for (int i = 0; i < 6; i++) begin
            count_while((i + 1) % 6, n);
            chk("free_len", 32'(n), 32'(exp_len[i]));
            total += n;
        end
        chk("free_period", 32'(total), 32'd38);

        // req_b pulse at A_G timer=7.
        wait_m(1, 7);
        cyc(0, 1);
        cyc(0, 0);
        chk("s3_pend_b", 32'(bus.pend_b), 32'd1);
        cyc(0, 0);
        chk("s3_enter_ay", 32'(bus.phase), 32'd2);
        wait_bus(4);
        chk("s3_clear_bg", 32'(bus.pend_b), 32'd0);

        // req_b pulse at A_G timer=2: green held to MIN_GREEN, yellow full.
        wait_m(1, 2);
        cyc(0, 1);
        count_while(1, n);
        chk("s4_ag_len", 32'(n + 1), 32'(MIN_GREEN));
        count_while(2, n);
        chk("s4_ay_len", 32'(n), 32'd5);

        // Both requests at A_G timer=6.
        wait_m(1, 6);
        cyc(1, 1);
        cyc(0, 0);
        chk("s5_pend", 32'({bus.pend_a, bus.pend_b}), 32'b01);
        cyc(0, 0);
        chk("s5_enter_ay", 32'(bus.phase), 32'd2);
        wait_bus(4);
        count_while(4, n);
        chk("s5_bg_len", 32'(n), 32'd12);

        // req_a held through B_Y and AR_A.
        wait_m(5, 1);
        while (m_ph == 5 || m_ph == 0) cyc(1, 0);
        chk("s6_pend_a_set", 32'(bus.pend_a), 32'd1);
        cyc(0, 0);
        chk("s6_pend_a_clr", 32'(bus.pend_a), 32'd0);
        count_while(1, n);
        chk("s6_ag_len", 32'(n), 32'd12);

        // Illegal code recovers to AR_A, timer 1, on the next edge.
        force dut.state = 3'd6;
        #1;
        chk("ill_forced", 32'(bus.phase), 32'd6);
        release dut.state;
        m_ph = 0;
        m_t  = 1;
        cyc(0, 0);
        chk("ill_recover", 32'(bus.phase), 32'd0);

        // Reset in the middle of B_G with a request pending.
        wait_m(4, 1);
        cyc(1, 0);
        cyc(0, 0);
        chk("r_pre_pend", 32'(bus.pend_a), 32'd1);
        do_reset(3);
        count_while(0, n);
        chk("r_arA_len", 32'(n), 32'd2);

        // Random requests with occasional async reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0)
                do_reset(int'($urandom_range(1, 3)));
            else
                cyc($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        cmp_all();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
